// File: rtl/tree_add_sched_if.sv
// Operand/result handshake bundle for tree_add_sched.
//   in_valid/in_ready/in_data/in_last : operand stream into the block
//   out_valid/out_ready/out_sum/out_count : one result per operand set
// Modports: slave = the adder block, master = the producer/consumer side.
interface tree_add_sched_if #(
    parameter int unsigned W    = 18,
    parameter int unsigned LOGN = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [W+LOGN-1:0] out_sum;
    logic [LOGN:0]     out_count;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count
    );
endinterface

// File: rtl/tree_add_sched.sv
// Sequential tree adder: buffers up to NOPS unsigned operands, then reduces
// them pairwise in tree order with a single shared adder (one add per cycle).
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : tree_add_sched_if.slave (operand in, sum/count out)
//   busy     : high while reducing or holding a result
// Build option: define TREE_EARLY_EN to stop the reduction once only the
// occupied slots have been folded (shorter latency, identical results).
module tree_add_sched #(
    parameter int unsigned W    = 18,
    parameter int unsigned NOPS = 8,
    parameter int unsigned LOGN = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    tree_add_sched_if.slave      bus,
    output logic                 busy
);
    localparam int unsigned SW = W + LOGN;
    localparam int unsigned CW = LOGN + 1;

    typedef enum logic [1:0] {LOAD = 2'd0, REDUCE = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   slot_q [NOPS];
    logic [SW-1:0]   slot_d [NOPS];
    logic [CW-1:0]   cnt_q, cnt_d;       // accepted count; low bits are the write index
    logic [CW-1:0]   live_q, live_d;     // operands still to fold at the current level
    logic [LOGN-1:0] pair_q, pair_d;     // pair index within the current level
    logic [CW-1:0]   npairs_c;
    logic [SW-1:0]   sum_c;
    logic            accept_c;

    assign accept_c = bus.in_valid && (state_q == LOAD);
    // ceil(live/2) pairs per level; with live=NOPS this is the full tree
    assign npairs_c = (live_q + CW'(1)) >> 1;
    // Shared adder: in-place is safe since pair p writes slot p after its
    // readers (pairs <= p/2) have already consumed it
    assign sum_c    = slot_q[LOGN'({pair_q, 1'b0})] + slot_q[LOGN'({pair_q, 1'b1})];

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = slot_q[0];
    assign bus.out_count = cnt_q;
    assign busy          = (state_q != LOAD);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            live_q  <= '0;
            pair_q  <= '0;
            for (int i = 0; i < NOPS; i++) slot_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= live_d;
            pair_q  <= pair_d;
            slot_q  <= slot_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        live_d  = live_q;
        pair_d  = pair_q;
        slot_d  = slot_q;
        case (state_q)
            LOAD: begin
                if (accept_c) begin
                    slot_d[cnt_q[LOGN-1:0]] = SW'(bus.in_data);
                    cnt_d = cnt_q + CW'(1);
                    if (bus.in_last || (cnt_q == CW'(NOPS - 1))) begin
                        pair_d = '0;
`ifdef TREE_EARLY_EN
                        live_d  = cnt_q + CW'(1);
                        state_d = (cnt_q == '0) ? DONE : REDUCE;
`else
                        live_d  = CW'(NOPS);
                        state_d = REDUCE;
`endif
                    end
                end
            end
            REDUCE: begin
                slot_d[pair_q] = sum_c;
                if ({1'b0, pair_q} == (npairs_c - CW'(1))) begin
                    pair_d = '0;
                    live_d = npairs_c;
                    if (npairs_c == CW'(1)) state_d = DONE;
                end else begin
                    pair_d = pair_q + LOGN'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    live_d  = '0;
                    pair_d  = '0;
                    for (int i = 0; i < NOPS; i++) slot_d[i] = '0;
                end
            end
            default: state_d = LOAD;
        endcase
    end
endmodule

// File: doc/tree_add_sched.md
TREE_ADD_SCHED -- requirements
Module: tree_add_sched

Interface
REQ-001 Parameter W, default 18, operand width in bits.
REQ-002 Parameter NOPS, default 8, operand slots per set; power of two, range 2..16.
REQ-003 Parameter LOGN, default 3, equal to log2(NOPS).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 in_valid  input  1  operand offered.
REQ-007 in_ready  output  1  block accepts an operand.
REQ-008 in_data  input  W  unsigned operand.
REQ-009 in_last  input  1  marks the final operand of a set; sampled only with the accepted operand.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 out_sum  output  W+LOGN  unsigned sum of the set.
REQ-013 out_count  output  LOGN+1  number of operands accepted in the set.
REQ-014 busy  output  1  high whenever the FSM is in REDUCE or DONE.

Function
REQ-015 The FSM SHALL have three states: LOAD, REDUCE and DONE.
REQ-016 in_ready SHALL be 1 only in LOAD; an operand is accepted on any edge with in_valid and in_ready both high.
REQ-017 Each accepted operand SHALL be written, zero-extended to W+LOGN, into buffer slot idx; idx then increments.
REQ-018 The FSM SHALL go LOAD->REDUCE on the accept edge if in_last=1 or idx=NOPS-1. Slots never written hold 0.
REQ-019 In REDUCE, the block SHALL perform exactly one addition per cycle using one shared adder, in tree order.
  - For level 1..LOGN and, within each level, pair p ascending: buf[p] <= buf[2p] + buf[2p+1].
  - Level L has NOPS>>L pairs.
REQ-020 Without the Configuration feature, REDUCE SHALL last exactly NOPS-1 cycles.
  - The final addition edge moves the FSM to DONE.
  - out_valid is first high NOPS-1 cycles after the last-accept edge (7 for NOPS=8).
REQ-021 In DONE, the outputs SHALL behave as follows:
  - out_valid=1.
  - out_sum=buf[0].
  - out_count equals the accepted count.
  - out_sum and out_count stay stable until an edge with out_ready=1.
REQ-022 The out_valid and out_ready handshake edge SHALL move the FSM to LOAD, clear all slots, and clear idx and the count.
  - in_ready rises the following cycle; no operand is accepted on the handshake edge.
REQ-023 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside LOAD.
REQ-024 Arithmetic SHALL be unsigned, with W+LOGN-bit intermediate and result widths; overflow is impossible by construction.

Reset
REQ-025 When rst=1 at an edge, the block SHALL:
  - enter LOAD;
  - clear idx, the count and all slots;
  - set out_valid=0, in_ready=1, busy=0, out_sum=0 and out_count=0 after that edge.
REQ-026 Reset asserted in any state, including mid-REDUCE or DONE awaiting out_ready, SHALL abandon the set with no result emitted; rst has priority over every handshake.

Configuration
REQ-027 Macro TREE_EARLY_EN SHALL enable occupancy-based early termination.
  - When defined, level processing starts with c = accepted count.
  - Each level performs only the pairs p < ceil(c/2), then sets c = ceil(c/2).
  - Reduction ends when c = 1.
  - A set of 1 operand goes directly from LOAD to DONE on its accept edge.
  - REDUCE length = sum of the ceil values over the levels.
REQ-028 When TREE_EARLY_EN is undefined, the behaviour in REQ-020 SHALL apply regardless of count; results are identical either way, and only latency differs.

Verification
REQ-029 NOPS=8, operands 1..8, in_last on the 8th -> out_valid 7 cycles after the last accept; out_sum=36; out_count=8.
REQ-030 Operands 100, 200, 300 with in_last on the 3rd, macro undefined -> out_sum=600, out_count=3, latency 7 cycles.
  - Same stimulus with TREE_EARLY_EN defined -> latency 3 cycles (2+1).
REQ-031 Eight operands of 262143 -> out_sum=2097144 (0x1FFFF8), with no truncation.
REQ-032 out_ready held low for 5 cycles in DONE -> out_valid, out_sum and out_count stay stable; in_ready=0 throughout; in_ready=1 the cycle after the handshake.
REQ-033 rst pulsed at the 3rd REDUCE cycle -> out_valid never rises for that set; in_ready=1 after the reset edge.
  - The next set 5, 6 (in_last) -> out_sum=11.
REQ-034 TREE_EARLY_EN defined, single operand 42 with in_last -> out_valid=1 the cycle after the accept; out_sum=42; out_count=1.
